// File: rtl/lu_row_store_pkg.sv
// Shared definitions for the LU row store.
//   - Default geometry (matrix size, part width, channel count).
//   - clog2_min1: index width helper that never returns 0.
//   - elem_t / row_t: default-geometry element and row views.
//   - ch_state_e: per-channel lifecycle state.
package lu_row_store_pkg;

  localparam int SIZE_DEF   = 4;
  localparam int WIDTH_DEF  = 64;
  localparam int NUM_CH_DEF = 2;

  // A 1-channel store still needs a 1-bit channel port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW_DEF   = $clog2(SIZE_DEF);
  localparam int CH_W_DEF = clog2_min1(NUM_CH_DEF);

  typedef logic [2*WIDTH_DEF-1:0] elem_t;     // {imag, real}
  typedef elem_t [SIZE_DEF-1:0]   row_t;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    LOADING   = 2'd1,
    READY     = 2'd2,
    UNLOADING = 2'd3
  } ch_state_e;

endpackage

// File: rtl/lu_row_store_perm_table.sv
// One channel's logical->physical row map.
//   clr_i           : return to identity (takes priority over swap)
//   swap_i          : exchange entries swap_a_i and swap_b_i (a==b is harmless)
//   lk_a_i / lk_b_i : two independent lookups of the current (pre-update) map
//   phys_a_o/_b_o   : physical rows for the two lookups
module lu_perm_table
  import lu_row_store_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  localparam int AW  = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          swap_i,
  input  logic [AW-1:0] swap_a_i,
  input  logic [AW-1:0] swap_b_i,
  input  logic [AW-1:0] lk_a_i,
  input  logic [AW-1:0] lk_b_i,
  output logic [AW-1:0] phys_a_o,
  output logic [AW-1:0] phys_b_o
);

  logic [AW-1:0] perm_q [SIZE];
  logic [AW-1:0] perm_d [SIZE];

  always_comb begin
    for (int i = 0; i < SIZE; i++) perm_d[i] = perm_q[i];
    if (clr_i) begin
      for (int i = 0; i < SIZE; i++) perm_d[i] = AW'(i);
    end else if (swap_i) begin
      perm_d[swap_a_i] = perm_q[swap_b_i];
      perm_d[swap_b_i] = perm_q[swap_a_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SIZE; i++) perm_q[i] <= AW'(i);
    end else begin
      for (int i = 0; i < SIZE; i++) perm_q[i] <= perm_d[i];
    end
  end

  // Lookups see the map before this cycle's swap/clear takes effect.
  assign phys_a_o = perm_q[lk_a_i];
  assign phys_b_o = perm_q[lk_b_i];

endmodule

// File: rtl/lu_row_store.sv
// Multi-channel complex matrix row store for the LU engine.
//   load_*   : row-by-row load of a whole SIZExSIZE matrix into an EMPTY channel
//   rd_*     : engine row read through the channel's permutation, 1-cycle latency
//   wr_*     : engine row write-back through the permutation (READY channels only)
//   swap_*   : pivot row swap done by remapping the permutation
//   unload_* / out_* : stream a READY channel out in logical row order, valid/ready
//   busy_o   : some channel is loading or unloading
// Row memory is one flat array of NUM_CH*SIZE rows addressed {channel, physical row}
// with a single read port shared by engine reads (priority) and unload fetches.
module lu_row_store
  import lu_row_store_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  localparam int AW     = $clog2(SIZE),
  localparam int CH_W   = clog2_min1(NUM_CH),
  localparam int ROW_W  = SIZE * 2 * WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CH_W-1:0]  load_ch_i,
  input  logic [ROW_W-1:0] load_row_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [CH_W-1:0]  rd_ch_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic             rd_valid_i,
  output logic [ROW_W-1:0] rd_row_o,
  output logic [AW-1:0]    rd_addr_o,
  output logic             rd_valid_o,
  output logic             rd_err_o,
  input  logic [CH_W-1:0]  wr_ch_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [ROW_W-1:0] wr_row_i,
  input  logic             wr_valid_i,
  input  logic             swap_valid_i,
  input  logic [CH_W-1:0]  swap_ch_i,
  input  logic [AW-1:0]    swap_a_i,
  input  logic [AW-1:0]    swap_b_i,
  input  logic             unload_start_i,
  input  logic [CH_W-1:0]  unload_ch_i,
  output logic [ROW_W-1:0] out_row_o,
  output logic [AW-1:0]    out_addr_o,
  output logic [CH_W-1:0]  out_ch_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  localparam int            MW       = CH_W + AW;
  localparam logic [AW-1:0] LAST_ROW = AW'(SIZE - 1);
  localparam logic [AW:0]   CNT_END  = (AW+1)'(SIZE);

  function automatic logic ch_ok(input logic [CH_W-1:0] ch);
    return int'(ch) < NUM_CH;
  endfunction

  // Channel state and control flops.
  ch_state_e        st_q [NUM_CH];
  ch_state_e        st_d [NUM_CH];
  logic             load_act_q, load_act_d;
  logic [CH_W-1:0]  load_ch_q, load_ch_d;
  logic [AW-1:0]    load_cnt_q, load_cnt_d;
  logic [CH_W-1:0]  uch_q, uch_d;
  logic [AW:0]      fetch_cnt_q, fetch_cnt_d;

  // Output flops.
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [AW-1:0]    out_addr_q, out_addr_d;
  logic             out_valid_q, out_valid_d;

  logic [ROW_W-1:0] mem_q [NUM_CH*SIZE];

  // Decoded events for this cycle.
  logic             unl_act;
  logic             load_acc, load_first, load_last;
  logic [CH_W-1:0]  load_tgt;
  logic             rd_ok, wr_ok, sw_ok;
  logic             unl_start_ok, unl_done, fetch_en;

  logic [NUM_CH-1:0] perm_clr, perm_swap;
  logic [AW-1:0]     lk_a   [NUM_CH];
  logic [AW-1:0]     phys_a [NUM_CH];
  logic [AW-1:0]     phys_b [NUM_CH];
  logic [MW-1:0]     rd_idx, wr_idx, ld_idx;
  logic [ROW_W-1:0]  rdata;

  // ---------------------------------------------------------------------------
  // Channel FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) st_q[c] <= EMPTY;
    end else begin
      for (int c = 0; c < NUM_CH; c++) st_q[c] <= st_d[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c] = st_q[c];
      unique case (st_q[c])
        EMPTY:     if (load_first && load_tgt == CH_W'(c)) st_d[c] = LOADING;
        LOADING:   if (load_last && load_ch_q == CH_W'(c)) st_d[c] = READY;
        READY:     if (unl_start_ok && unload_ch_i == CH_W'(c)) st_d[c] = UNLOADING;
        UNLOADING: if (unl_done && uch_q == CH_W'(c)) st_d[c] = EMPTY;
        default:   st_d[c] = EMPTY;
      endcase
    end
  end

  always_comb begin
    unl_act = 1'b0;
    busy_o  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (st_q[c] == UNLOADING) unl_act = 1'b1;
      if (st_q[c] == LOADING || st_q[c] == UNLOADING) busy_o = 1'b1;
    end
    // Once a load has started, later rows follow the channel latched with row 0.
    load_ready_o = load_act_q || (ch_ok(load_ch_i) && st_q[load_ch_i] == EMPTY);
  end

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    load_tgt     = load_act_q ? load_ch_q : load_ch_i;
    load_acc     = load_valid_i && load_ready_o;
    load_first   = load_acc && !load_act_q;
    load_last    = load_acc && load_act_q && load_cnt_q == LAST_ROW;

    rd_ok        = rd_valid_i   && ch_ok(rd_ch_i)   && st_q[rd_ch_i]   == READY;
    wr_ok        = wr_valid_i   && ch_ok(wr_ch_i)   && st_q[wr_ch_i]   == READY;
    sw_ok        = swap_valid_i && ch_ok(swap_ch_i) && st_q[swap_ch_i] == READY;

    unl_start_ok = unload_start_i && !unl_act && ch_ok(unload_ch_i)
                   && st_q[unload_ch_i] == READY;
    unl_done     = out_valid_q && out_ready_i && out_addr_q == LAST_ROW;
    // Engine reads own the read port; unload fetches only into a free or freeing slot.
    fetch_en     = unl_act && !rd_valid_i && fetch_cnt_q < CNT_END
                   && (!out_valid_q || out_ready_i);

    for (int c = 0; c < NUM_CH; c++) begin
      perm_clr[c]  = (load_first && load_tgt == CH_W'(c))
                     || (unl_done && uch_q == CH_W'(c));
      perm_swap[c] = sw_ok && swap_ch_i == CH_W'(c);
      // An unloading channel never serves engine reads, so its lookup port A
      // can be lent to the unload fetch.
      lk_a[c]      = (st_q[c] == UNLOADING) ? fetch_cnt_q[AW-1:0] : rd_addr_i;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_perm
    lu_perm_table #(
      .SIZE (SIZE)
    ) u_perm (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (perm_clr[c]),
      .swap_i   (perm_swap[c]),
      .swap_a_i (swap_a_i),
      .swap_b_i (swap_b_i),
      .lk_a_i   (lk_a[c]),
      .lk_b_i   (wr_addr_i),
      .phys_a_o (phys_a[c]),
      .phys_b_o (phys_b[c])
    );
  end

  // ---------------------------------------------------------------------------
  // Row memory: shared read port, load and write-back write ports
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_idx = rd_valid_i ? {rd_ch_i, phys_a[rd_ch_i]} : {uch_q, phys_a[uch_q]};
    wr_idx = {wr_ch_i, phys_b[wr_ch_i]};
    ld_idx = {load_tgt, load_cnt_q};
    rdata  = mem_q[rd_idx];
  end

  // Load and write-back never target the same channel (LOADING vs READY).
  // Reads are taken from the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (load_acc) mem_q[ld_idx] <= load_row_i;
      if (wr_ok)    mem_q[wr_idx] <= wr_row_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    load_act_d  = load_act_q;
    load_ch_d   = load_ch_q;
    load_cnt_d  = load_cnt_q;
    if (load_first) begin
      load_act_d = 1'b1;
      load_ch_d  = load_ch_i;
    end
    if (load_last) load_act_d = 1'b0;
    // Wraps back to 0 after the last row since SIZE is a power of two.
    if (load_acc) load_cnt_d = load_cnt_q + 1'b1;

    uch_d       = unl_start_ok ? unload_ch_i : uch_q;
    fetch_cnt_d = fetch_cnt_q;
    if (unl_start_ok)  fetch_cnt_d = '0;
    else if (fetch_en) fetch_cnt_d = fetch_cnt_q + 1'b1;

    rd_valid_d  = rd_ok;
    rd_err_d    = rd_valid_i && !rd_ok;
    rd_addr_d   = rd_ok ? rd_addr_i : rd_addr_q;
    rd_row_d    = rd_ok ? rdata : rd_row_q;

    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_row_d   = out_row_q;
    if (fetch_en) begin
      out_valid_d = 1'b1;
      out_addr_d  = fetch_cnt_q[AW-1:0];
      out_row_d   = rdata;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_act_q  <= 1'b0;
      load_ch_q   <= '0;
      load_cnt_q  <= '0;
      uch_q       <= '0;
      fetch_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_row_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_row_q   <= '0;
    end else begin
      load_act_q  <= load_act_d;
      load_ch_q   <= load_ch_d;
      load_cnt_q  <= load_cnt_d;
      uch_q       <= uch_d;
      fetch_cnt_q <= fetch_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      rd_addr_q   <= rd_addr_d;
      rd_row_q    <= rd_row_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_row_q   <= out_row_d;
    end
  end

  assign rd_row_o    = rd_row_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_err_o    = rd_err_q;
  assign out_row_o   = out_row_q;
  assign out_addr_o  = out_addr_q;
  assign out_ch_o    = uch_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_lu_row_store.sv
// Directed bench for lu_row_store: load, read, swap, write-back collision,
// stalled unload, concurrent load/unload and mid-unload reset.
module tb_lu_row_store;

  localparam int SIZE   = 4;
  localparam int WIDTH  = 64;
  localparam int NUM_CH = 2;
  localparam int AW     = 2;
  localparam int CH_W   = 1;
  localparam int ROW_W  = SIZE * 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [CH_W-1:0]  load_ch_i;
  logic [ROW_W-1:0] load_row_i;
  logic             load_valid_i;
  logic             load_ready_o;
  logic [CH_W-1:0]  rd_ch_i;
  logic [AW-1:0]    rd_addr_i;
  logic             rd_valid_i;
  logic [ROW_W-1:0] rd_row_o;
  logic [AW-1:0]    rd_addr_o;
  logic             rd_valid_o;
  logic             rd_err_o;
  logic [CH_W-1:0]  wr_ch_i;
  logic [AW-1:0]    wr_addr_i;
  logic [ROW_W-1:0] wr_row_i;
  logic             wr_valid_i;
  logic             swap_valid_i;
  logic [CH_W-1:0]  swap_ch_i;
  logic [AW-1:0]    swap_a_i;
  logic [AW-1:0]    swap_b_i;
  logic             unload_start_i;
  logic [CH_W-1:0]  unload_ch_i;
  logic [ROW_W-1:0] out_row_o;
  logic [AW-1:0]    out_addr_o;
  logic [CH_W-1:0]  out_ch_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             busy_o;

  always #5 clk = ~clk;

  lu_row_store #(
    .SIZE   (SIZE),
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .load_ch_i      (load_ch_i),
    .load_row_i     (load_row_i),
    .load_valid_i   (load_valid_i),
    .load_ready_o   (load_ready_o),
    .rd_ch_i        (rd_ch_i),
    .rd_addr_i      (rd_addr_i),
    .rd_valid_i     (rd_valid_i),
    .rd_row_o       (rd_row_o),
    .rd_addr_o      (rd_addr_o),
    .rd_valid_o     (rd_valid_o),
    .rd_err_o       (rd_err_o),
    .wr_ch_i        (wr_ch_i),
    .wr_addr_i      (wr_addr_i),
    .wr_row_i       (wr_row_i),
    .wr_valid_i     (wr_valid_i),
    .swap_valid_i   (swap_valid_i),
    .swap_ch_i      (swap_ch_i),
    .swap_a_i       (swap_a_i),
    .swap_b_i       (swap_b_i),
    .unload_start_i (unload_start_i),
    .unload_ch_i    (unload_ch_i),
    .out_row_o      (out_row_o),
    .out_addr_o     (out_addr_o),
    .out_ch_o       (out_ch_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [ROW_W-1:0] got,
                     input logic [ROW_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Every element of the row is {imag=-v, real=v} as IEEE doubles.
  function automatic logic [ROW_W-1:0] mk_row(input real v);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) r[i*2*WIDTH +: 2*WIDTH] = {$realtobits(-v), $realtobits(v)};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mat(input int ch, input real base);
    for (int k = 0; k < SIZE; k++) begin
      load_ch_i    = CH_W'(ch);
      load_row_i   = mk_row(base + k);
      load_valid_i = 1'b1;
      #1;
      chk("load_ready", load_ready_o, 1'b1);
      tick();
      if (k == 0) chk("busy_loading", busy_o, 1'b1);
    end
    load_valid_i = 1'b0;
  endtask

  task automatic do_read(input int ch, input int addr);
    rd_ch_i    = CH_W'(ch);
    rd_addr_i  = AW'(addr);
    rd_valid_i = 1'b1;
    tick();
    rd_valid_i = 1'b0;
  endtask

  task automatic do_swap(input int ch, input int a, input int b);
    swap_ch_i    = CH_W'(ch);
    swap_a_i     = AW'(a);
    swap_b_i     = AW'(b);
    swap_valid_i = 1'b1;
    tick();
    swap_valid_i = 1'b0;
  endtask

  // Unload a channel, checking rows in logical order; optionally stall with the
  // ready pattern 1,0,0,1 and return after stop_after handshakes.
  task automatic do_unload(input int ch, input real e0, input real e1, input real e2,
                           input real e3, input logic stall, input int stop_after);
    real              ev [4];
    logic [3:0]       pat;
    logic [ROW_W-1:0] prow;
    logic [AW-1:0]    paddr;
    logic             stalled;
    int               hs;
    int               cyc;
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    pat = 4'b1001;
    stalled = 1'b0;
    prow = '0;
    paddr = '0;
    hs = 0;
    cyc = 0;
    unload_ch_i    = CH_W'(ch);
    unload_start_i = 1'b1;
    tick();
    unload_start_i = 1'b0;
    while (hs < stop_after && cyc < 60) begin
      out_ready_i = stall ? pat[cyc % 4] : 1'b1;
      if (stalled) begin
        chk("hold_valid", out_valid_o, 1'b1);
        chk("hold_row", out_row_o, prow);
        chk("hold_addr", out_addr_o, paddr);
      end
      stalled = 1'b0;
      if (out_valid_o) begin
        if (out_ready_i) begin
          chk("out_addr", out_addr_o, hs);
          chk("out_row", out_row_o, mk_row(ev[hs]));
          chk("out_ch", out_ch_o, ch);
          hs++;
        end else begin
          stalled = 1'b1;
          prow    = out_row_o;
          paddr   = out_addr_o;
        end
      end
      tick();
      cyc++;
    end
    if (hs < stop_after) chk("unload_timeout", hs, stop_after);
    out_ready_i = 1'b1;
  endtask

  initial begin
    int li;
    int hs;
    int cyc;
    logic lacc;

    rst_i = 1'b1;
    load_ch_i = '0; load_row_i = '0; load_valid_i = 1'b0;
    rd_ch_i = '0; rd_addr_i = '0; rd_valid_i = 1'b0;
    wr_ch_i = '0; wr_addr_i = '0; wr_row_i = '0; wr_valid_i = 1'b0;
    swap_valid_i = 1'b0; swap_ch_i = '0; swap_a_i = '0; swap_b_i = '0;
    unload_start_i = 1'b0; unload_ch_i = '0; out_ready_i = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_rd_valid", rd_valid_o, 1'b0);
    chk("rst_rd_err", rd_err_o, 1'b0);
    chk("rst_rd_row", rd_row_o, '0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_load_ready", load_ready_o, 1'b1);
    rst_i = 1'b0;
    tick();

    // 1: load ch0 with rows 1..4, read logical 2
    load_mat(0, 1.0);
    chk("busy_after_load", busy_o, 1'b0);
    do_read(0, 2);
    chk("t1_rd_valid", rd_valid_o, 1'b1);
    chk("t1_rd_addr", rd_addr_o, 2);
    chk("t1_rd_row", rd_row_o, mk_row(3.0));

    // 2: swap(0,3), read 0, unload in permuted order
    do_swap(0, 0, 3);
    do_read(0, 0);
    chk("t2_rd_row", rd_row_o, mk_row(4.0));
    do_swap(0, 2, 2);
    do_read(0, 2);
    chk("t2_self_swap", rd_row_o, mk_row(3.0));
    do_unload(0, 4.0, 2.0, 3.0, 1.0, 1'b0, 4);
    chk("t2_out_valid_end", out_valid_o, 1'b0);

    // 3: read-before-write on the same logical row (perm back to identity)
    load_mat(0, 1.0);
    wr_ch_i = 1'b0; wr_addr_i = AW'(1); wr_row_i = mk_row(9.0); wr_valid_i = 1'b1;
    rd_ch_i = 1'b0; rd_addr_i = AW'(1); rd_valid_i = 1'b1;
    tick();
    wr_valid_i = 1'b0;
    rd_valid_i = 1'b0;
    chk("t3_rbw_old", rd_row_o, mk_row(2.0));
    do_read(0, 1);
    chk("t3_rd_new", rd_row_o, mk_row(9.0));

    // 4: unload with back-pressure
    do_unload(0, 1.0, 9.0, 3.0, 4.0, 1'b1, 4);
    load_ch_i = 1'b0;
    #1;
    chk("t4_busy", busy_o, 1'b0);
    chk("t4_load_ready", load_ready_o, 1'b1);
    do_read(0, 0);
    chk("t4_rd_err_empty", rd_err_o, 1'b1);

    // 5: read to EMPTY ch1, then load ch1 while ch0 unloads
    do_read(1, 0);
    chk("t5_rd_err", rd_err_o, 1'b1);
    chk("t5_rd_valid", rd_valid_o, 1'b0);
    tick();
    chk("t5_rd_err_pulse", rd_err_o, 1'b0);
    load_mat(0, 5.0);
    unload_ch_i = 1'b0;
    unload_start_i = 1'b1;
    load_ch_i = 1'b1;
    li = 0;
    hs = 0;
    cyc = 0;
    while ((li < SIZE || hs < SIZE) && cyc < 60) begin
      load_valid_i = (li < SIZE);
      load_row_i   = mk_row(11.0 + li);
      out_ready_i  = 1'b1;
      #1;
      lacc = load_valid_i && load_ready_o;
      if (out_valid_o) begin
        chk("t5_out_addr", out_addr_o, hs);
        chk("t5_out_row", out_row_o, mk_row(5.0 + hs));
        hs++;
      end
      tick();
      unload_start_i = 1'b0;
      if (lacc) li++;
      cyc++;
    end
    load_valid_i = 1'b0;
    chk("t5_loaded_rows", li, SIZE);
    chk("t5_unloaded_rows", hs, SIZE);
    chk("t5_busy", busy_o, 1'b0);
    do_read(1, 3);
    chk("t5_rd_ch1", rd_row_o, mk_row(14.0));

    // 6: reset after two rows of an unload
    load_mat(0, 21.0);
    do_swap(0, 1, 2);
    do_unload(0, 21.0, 23.0, 22.0, 24.0, 1'b0, 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_out_valid", out_valid_o, 1'b0);
    chk("t6_out_row", out_row_o, '0);
    chk("t6_out_addr", out_addr_o, '0);
    chk("t6_rd_row", rd_row_o, '0);
    chk("t6_rd_valid", rd_valid_o, 1'b0);
    chk("t6_busy", busy_o, 1'b0);
    load_ch_i = 1'b1;
    #1;
    chk("t6_ch1_empty", load_ready_o, 1'b1);
    do_read(1, 0);
    chk("t6_ch1_err", rd_err_o, 1'b1);
    load_mat(0, 31.0);
    do_read(0, 1);
    chk("t6_rd1", rd_row_o, mk_row(32.0));
    do_read(0, 2);
    chk("t6_rd2", rd_row_o, mk_row(33.0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
